// File: rtl/fdiv_issue_if.sv
// Operand/result bundle shared by fdiv_issue and its neighbours: producer
// handshake, divide-core operand/quotient path, consumer handshake and busy.
interface fdiv_issue_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic [N-1:0]     core_a;
    logic [N-1:0]     core_b;
    logic [N-1:0]     core_out;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_result;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;
    logic             busy;

    // master is the surroundings (producer, core, consumer); slave is fdiv_issue
    modport master (
        output in_valid, in_a, in_b, in_tag, core_out, out_ready,
        input  in_ready, core_a, core_b, out_valid, out_result, out_tag, out_flags, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, core_out, out_ready,
        output in_ready, core_a, core_b, out_valid, out_result, out_tag, out_flags, busy
    );
endinterface

// File: rtl/fdiv_issue.sv
// Issue/retire wrapper around the combinational fdiv core: operand FIFO,
// registered core-operand stage and a sanitised, flagged result stage.
module fdiv_issue #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic        clk,
    input logic        rst,
    fdiv_issue_if.slave bus
);
    localparam int EW = (N == 64) ? 11 : 8;
    localparam int MW = N - 1 - EW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [N-1:0]     q_a   [DEPTH];
    logic [N-1:0]     q_b   [DEPTH];
    logic [TAG_W-1:0] q_tag [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             c_valid;
    logic [N-1:0]     c_a;
    logic [N-1:0]     c_b;
    logic [TAG_W-1:0] c_tag;

    logic             r_valid;
    logic [N-1:0]     r_result;
    logic [TAG_W-1:0] r_tag;
    logic [2:0]       r_flags;

    logic push, pop, c_load, r_load;

    assign bus.in_ready = (count < FULL);
    assign push   = bus.in_valid & bus.in_ready;
    assign r_load = c_valid & (!r_valid | bus.out_ready);
    assign c_load = (count != '0) & (!c_valid | r_load);
    assign pop    = c_load;

    // Storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_a[wr_ptr]   <= bus.in_a;
            q_b[wr_ptr]   <= bus.in_b;
            q_tag[wr_ptr] <= bus.in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push & !pop)      count <= count + 1'b1;
            else if (pop & !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_tag   <= '0;
        end else if (c_load) begin
            c_valid <= 1'b1;
            c_a     <= q_a[rd_ptr];
            c_b     <= q_b[rd_ptr];
            c_tag   <= q_tag[rd_ptr];
        end else if (r_load) begin
            c_valid <= 1'b0;
        end
    end

    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic [N-1:0] res;
    logic [2:0]   flags;

    assign ea = c_a[N-2 -: EW];
    assign eb = c_b[N-2 -: EW];
    assign ma = c_a[MW-1:0];
    assign mb = c_b[MW-1:0];
    assign a_nan  = (&ea) & (|ma);
    assign b_nan  = (&eb) & (|mb);
    assign a_inf  = (&ea) & ~(|ma);
    assign b_inf  = (&eb) & ~(|mb);
    // Denormals collapse to zero, so only the exponent matters here.
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);
    assign sgn    = c_a[N-1] ^ c_b[N-1];

    always_comb begin
        res   = bus.core_out;
        flags = 3'b000;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            res   = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
            flags = 3'b101;
        end else if (b_zero & !a_inf) begin
            res   = {sgn, {EW{1'b1}}, {MW{1'b0}}};
            flags = 3'b011;
        end else if (a_inf) begin
            res   = {sgn, {EW{1'b1}}, {MW{1'b0}}};
            flags = 3'b001;
        end else if (a_zero | b_inf) begin
            res   = {sgn, {(N-1){1'b0}}};
            flags = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_tag    <= '0;
            r_flags  <= '0;
        end else if (r_load) begin
            r_valid  <= 1'b1;
            r_result <= res;
            r_tag    <= c_tag;
            r_flags  <= flags;
        end else if (bus.out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign bus.core_a     = c_a;
    assign bus.core_b     = c_b;
    assign bus.out_valid  = r_valid;
    assign bus.out_result = r_result;
    assign bus.out_tag    = r_tag;
    assign bus.out_flags  = r_flags;
    assign bus.busy       = (count != '0) | c_valid | r_valid;
endmodule

// File: tb/tb_fdiv_issue.sv
// Self-checking bench for fdiv_issue: a real-arithmetic divide core model
// drives core_out, and a queue-based reference model predicts every result.
module tb_fdiv_issue;
    logic clk;
    logic rst;

    fdiv_issue_if #(.N(32), .TAG_W(4)) bus ();

    fdiv_issue #(.N(32), .DEPTH(4), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_out    = 0;

    function automatic logic [63:0] sp2dp(input logic [31:0] a);
        if (a[30:23] == 8'h00) return {a[31], 63'h0};
        if (a[30:23] == 8'hFF) return {a[31], 11'h7FF, a[22:0], 29'h0};
        return {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'h0};
    endfunction

    // Stand-in for the divide core: exact real division, truncated back to single.
    function automatic logic [31:0] core_div(input logic [31:0] a, input logic [31:0] b);
        real ra, rb, q;
        logic [63:0] qd;
        logic [10:0] e;
        ra = $bitstoreal(sp2dp(a));
        rb = $bitstoreal(sp2dp(b));
        if (rb == 0.0) return 32'h0;
        q  = ra / rb;
        qd = $realtobits(q);
        e  = qd[62:52];
        if (e > 11'd1150 || e < 11'd897) return {qd[63], 31'h0};
        return {qd[63], 8'(e - 11'd896), qd[51:29]};
    endfunction

    assign bus.core_out = core_div(bus.core_a, bus.core_b);

    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] tag);
        exp_t e;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        s      = a[31] ^ b[31];
        e.tag  = tag;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            e.res = 32'h7FC00000; e.flags = 3'b101;
        end else if (b_zero && !a_inf) begin
            e.res = {s, 31'h7F800000}; e.flags = 3'b011;
        end else if (a_inf) begin
            e.res = {s, 31'h7F800000}; e.flags = 3'b001;
        end else if (a_zero || b_inf) begin
            e.res = {s, 31'h0}; e.flags = 3'b001;
        end else begin
            e.res = core_div(a, b); e.flags = 3'b000;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:       return {r[31], 31'h0};
            1:       return {r[31], 8'hFF, 23'h0};
            2:       return {r[31], 8'hFF, r[22:0] | 23'h1};
            3:       return {r[31], 8'h00, r[22:0]};
            default: return {r[31], 8'($urandom_range(64, 190)), r[22:0]};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tag, input logic rdy);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        bus.out_ready = rdy;
    endtask

    // One clock: score handshakes seen at this negedge, advance, verify stalls held.
    task automatic step();
        exp_t        e;
        logic        stalled;
        logic [38:0] held;
        checkOutput("busy", 64'(bus.busy), 64'(exp_q.size() != 0));
        if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_model(bus.in_a, bus.in_b, bus.in_tag));
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            checkOutput("output_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_result", bus.out_result, e.res);
                checkOutput("sb_tag",    bus.out_tag,    e.tag);
                checkOutput("sb_flags",  bus.out_flags,  e.flags);
            end
        end
        stalled = bus.out_valid && !bus.out_ready;
        held    = {bus.out_result, bus.out_tag, bus.out_flags};
        @(posedge clk);
        @(negedge clk);
        if (stalled) begin
            checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("hold_data", {bus.out_result, bus.out_tag, bus.out_flags}, held);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        while (exp_q.size() > 0 && n < bound) begin
            step();
            n++;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("drain_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic runOne(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags);
        int lat;
        applyStimulus(1'b1, a, b, tag, 1'b1);
        checkOutput("accept_ready", 64'(bus.in_ready), 64'd1);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        checkOutput("latency", 64'(lat), 64'd3);
        checkOutput("direct_result", bus.out_result, exp_res);
        checkOutput("direct_tag", bus.out_tag, tag);
        checkOutput("direct_flags", bus.out_flags, exp_flags);
        step();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int next_tag, acc_cnt, accepted, cyc, vis, out_base;
        logic v;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready",   64'(bus.in_ready),  64'd1);
        checkOutput("rst_out_valid",  64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_result", bus.out_result,     64'd0);
        checkOutput("rst_out_tag",    bus.out_tag,        64'd0);
        checkOutput("rst_out_flags",  bus.out_flags,      64'd0);
        checkOutput("rst_core_a",     bus.core_a,         64'd0);
        checkOutput("rst_core_b",     bus.core_b,         64'd0);
        checkOutput("rst_busy",       64'(bus.busy),      64'd0);

        $display("[TB] single op and specials");
        runOne(32'h40C00000, 32'h40000000, 4'd5, 32'h40400000, 3'b000);
        runOne(32'h3F800000, 32'h00000000, 4'd1, 32'h7F800000, 3'b011);
        runOne(32'h80000000, 32'h00000000, 4'd2, 32'h7FC00000, 3'b101);
        runOne(32'hFF800000, 32'h40000000, 4'd3, 32'hFF800000, 3'b001);
        runOne(32'h3F800000, 32'h7F800000, 4'd4, 32'h00000000, 3'b001);

        $display("[TB] backpressure");
        next_tag = 0;
        acc_cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, rand_fp(), rand_fp(), 4'(next_tag), 1'b0);
            if (bus.in_ready) begin
                next_tag++;
                acc_cnt++;
            end
            step();
        end
        checkOutput("full_accepted", 64'(acc_cnt), 64'd6);
        checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
        cyc = 0;
        while (next_tag < 8 && cyc < 50) begin
            applyStimulus(1'b1, rand_fp(), rand_fp(), 4'(next_tag), 1'b1);
            if (bus.in_ready) next_tag++;
            step();
            cyc++;
        end
        checkOutput("bp_all_offered", 64'(next_tag), 64'd8);
        drain(50);

        $display("[TB] streaming");
        vis = 0;
        for (int i = 0; i < 19; i++) begin
            if (bus.out_valid) vis++;
            if (i < 16) begin
                applyStimulus(1'b1, rand_fp(), rand_fp(), 4'(i), 1'b1);
                checkOutput("stream_in_ready", 64'(bus.in_ready), 64'd1);
            end else begin
                applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
            end
            step();
        end
        checkOutput("stream_results", 64'(vis), 64'd16);
        drain(20);

        $display("[TB] random traffic");
        out_base = n_out;
        accepted = 0;
        cyc      = 0;
        while (accepted < 1000 && cyc < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            applyStimulus(v, rand_fp(), rand_fp(), 4'($urandom), ($urandom_range(0, 1) == 1));
            if (v && bus.in_ready) accepted++;
            step();
            cyc++;
        end
        checkOutput("rand_accepted", 64'(accepted), 64'd1000);
        drain(100);
        checkOutput("rand_outputs", 64'(n_out - out_base), 64'd1000);

        $display("[TB] reset with ops in flight");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, rand_fp(), rand_fp(), 4'(i), 1'b0);
            step();
        end
        doReset();
        checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("mid_rst_busy",      64'(bus.busy),      64'd0);
        checkOutput("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        out_base = n_out;
        runOne(32'h40800000, 32'h40000000, 4'd9, 32'h40000000, 3'b000);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        repeat (6) step();
        checkOutput("post_rst_outputs", 64'(n_out - out_base), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fdiv_issue.md
# fdiv_issue

Operand issue and result retire stage for the combinational single-precision divide core (fdiv). It sits directly upstream of the core, buffering operand pairs from a valid/ready producer in a small FIFO and presenting one registered pair per cycle to the core. It also sits directly downstream of the core, capturing and sanitising the core's result into a registered valid/ready output with IEEE special-case overrides and exception flags. Full throughput is one divide per cycle, with minimum latency of 3 cycles.

## Interface
- N, 32: operand width. 32 gives fields 1/8/23; 64 gives fields 1/11/52. Field positions are derived from N.
- DEPTH, 4: operand FIFO entries. Must be a power of two, ≥2.
- TAG_W, 4: width of the user tag carried with each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept.
- in_a  in  N  dividend.
- in_b  in  N  divisor.
- in_tag  in  TAG_W  user tag.
- core_a  out  N  registered dividend to the divide core.
- core_b  out  N  registered divisor to the divide core.
- core_out  in  N  combinational quotient from the divide core.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_result  out  N  quotient.
- out_tag  out  TAG_W  tag of the result.
- out_flags  out  3  {nv, dz, sp}: invalid, divide-by-zero, special override applied.
- busy  out  1  any stage or FIFO entry occupied.

## Operation
- The block has three storage stages: FIFO (Q), core stage (C: c_valid, a, b, tag), and result stage (R: out_valid, result, tag, flags).
- core_a and core_b are driven only from C registers.
- Transfer conditions:
  - push = in_valid & in_ready.
  - r_load = c_valid & (!out_valid | out_ready).
  - c_load = (count>0) & (!c_valid | r_load); pop = c_load.
  - If !c_load & r_load, c_valid clears. If out_valid & out_ready & !r_load, out_valid clears.
- in_ready = (count < DEPTH), computed from registered count only. There is no same-cycle pass-through when full.
- count is a registered counter with range 0..DEPTH. It changes by +1 on push only, −1 on pop only, and is unchanged on push & pop together.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Classification of the C operands at r_load:
  - E = exponent field, M = mantissa field.
  - NaN: E all-ones and M≠0.
  - Inf: E all-ones and M=0.
  - Zero: E=0 and M=0.
  - Denormal inputs are treated as zero.
  - s = a.sign ^ b.sign.
- Result selection, in priority order:
  1. Either operand NaN, 0/0, or Inf/Inf → canonical qNaN (sign 0, E all-ones, M MSB 1, rest 0); nv=1, sp=1.
  2. Finite nonzero / 0 → signed Inf; dz=1, sp=1.
  3. Inf / finite → signed Inf; sp=1.
  4. 0 / nonzero, or finite / Inf → signed zero; sp=1.
  5. Otherwise → core_out unmodified; flags 0.
- busy = (count≠0) | c_valid | out_valid.
- Tags travel unmodified with their operands. Results emerge in issue order.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_result=0, out_tag=0, out_flags=0.
  - core_a=0, core_b=0, c_valid=0, count=0, pointers=0, busy=0.
  - FIFO storage is not cleared.
- Reset mid-operation discards every in-flight entry. No output handshake occurs during the cycle rst is high.
- Latency: a pair accepted at edge k is in Q after k. With the pipeline empty, it loads C at edge k+1 and R at edge k+2. out_valid is therefore high in the cycle after edge k+2, i.e. 3 cycles.
- Throughput: with out_ready held high, one result per cycle. in_ready stays high.
- Full: with out_ready=0, the block holds at most DEPTH+2 operations (Q full, C full, R full). in_ready=0 exactly while count==DEPTH.
- out_result, out_tag, and out_flags are stable while out_valid & !out_ready.
- In-flight data is never overwritten.
- Push and pop on the same edge at count==DEPTH−1 keeps count at DEPTH−1.
- Push and pop on the same edge at count==1 keeps count at 1.
- core_out is sampled only on the r_load edge. The core path is one combinational cycle from C to R.

## Test plan
- Single op, idle pipe, out_ready=1: a=0x40C00000, b=0x40000000, tag 5 → out_valid 3 cycles after accept; out_result = core_out for 6.0/2.0 = 0x40400000, tag 5, flags 000.
- Specials: 0x3F800000/0x00000000 → 0x7F800000 flags 011. 0x80000000/0x00000000 → 0x7FC00000 flags 101. 0xFF800000/0x40000000 → 0xFF800000 flags 001. 0x3F800000/0x7F800000 → 0x00000000 flags 001.
- Backpressure, DEPTH=4, out_ready=0, in_valid held with tags 0..7: exactly 6 accepted, then in_ready=0. After out_ready=1, tags emerge 0..7 in order with no loss or duplication. busy falls only after the last output.
- Streaming 16 ops with out_ready=1: one result per cycle, no bubbles, in_ready constantly 1.
- Random out_ready toggling over 1000 ops: output values are held stable while stalled, and order and count match the scoreboard.
- rst asserted with 5 ops in flight: the next cycle shows out_valid=0, busy=0, in_ready=1. A new op a=0x40800000, b=0x40000000 then yields 0x40000000 with no stale results.
